dmu_sii_inb_rcv: RTL and testbench

// - Receive stage on the SII side of the inbound DMU->SII interface.
// - Assembles header plus data beats into complete packets, checks parity, and buffers packets in a DEPTH-entry FIFO.
// - Hands packets to the SII inbound pipe over a valid/ready handshake.
// - Returns sii_dmu_wrack_* to the DMU for each write packet it hands off.

---
 rtl/dmu_sii_inb_rcv.sv | 222 ++++++++++++++++++++++
 tb/tb_dmu_sii_inb_rcv.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmu_sii_inb_rcv.sv
// SII-side receive stage for the inbound DMU->SII interface: packet assembly, DEPTH-entry packet FIFO,
// valid/ready hand-off and write-ack return. Optional parity checking under `DMU_SII_RCV_PARCHK_EN.
module dmu_sii_inb_rcv #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic           iol2clk,
    input  logic           rst_l,
    input  logic           dmu_sii_hdr_vld,
    input  logic           dmu_sii_reqbypass,
    input  logic           dmu_sii_datareq,
    input  logic           dmu_sii_datareq16,
    input  logic [127:0]   dmu_sii_data,
    input  logic [7:0]     dmu_sii_parity,
    input  logic [15:0]    dmu_sii_be,
    output logic           sii_dmu_wrack_vld,
    output logic [3:0]     sii_dmu_wrack_tag,
    output logic           rcv_vld,
    input  logic           rcv_rdy,
    output logic [127:0]   rcv_hdr,
    output logic [511:0]   rcv_data,
    output logic [15:0]    rcv_be,
    output logic [1:0]     rcv_len,
    output logic           rcv_bypass,
    output logic           rcv_full,
    output logic           rcv_ovf_err,
    output logic           rcv_proto_err,
    output logic           rcv_par_err
);

    typedef enum logic [0:0] {ST_IDLE, ST_DATA} state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [1:0]   r_beat_cnt;
    logic [127:0] r_hdr;
    logic         r_bypass;
    logic [1:0]   r_len;
    logic [383:0] r_data;

    logic         w_commit;
    logic         w_proto_set;
    logic [127:0] w_cm_hdr;
    logic [511:0] w_cm_data;
    logic [15:0]  w_cm_be;
    logic [1:0]   w_cm_len;
    logic         w_cm_bypass;

    logic [127:0] r_mem_hdr    [DEPTH];
    logic [511:0] r_mem_data   [DEPTH];
    logic [15:0]  r_mem_be     [DEPTH];
    logic [1:0]   r_mem_len    [DEPTH];
    logic         r_mem_bypass [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_ovf_err;
    logic             r_proto_err;
    logic             r_wrack_vld;
    logic [3:0]       r_wrack_tag;

    logic w_head_vld;
    logic w_full;
    logic w_pop;
    logic w_pop_wr;
    logic w_push;

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The final beat is never registered: it is merged straight into the committed payload.
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_proto_set = 1'b0;
        w_cm_hdr    = r_hdr;
        w_cm_bypass = r_bypass;
        w_cm_len    = r_len;
        w_cm_be     = 16'h0000;
        w_cm_data   = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (dmu_sii_hdr_vld) begin
                    w_proto_set = dmu_sii_datareq & dmu_sii_datareq16;
                    if (dmu_sii_datareq | dmu_sii_datareq16) begin
                        w_state_nxt = ST_DATA;
                    end else begin
                        w_commit    = 1'b1;
                        w_cm_hdr    = dmu_sii_data;
                        w_cm_bypass = dmu_sii_reqbypass;
                        w_cm_len    = 2'd0;
                    end
                end
            end
            ST_DATA: begin
                w_proto_set = dmu_sii_hdr_vld;
                if (r_beat_cnt == 2'd0) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_IDLE;
                    if (r_len == 2'd1) begin
                        w_cm_data = {384'd0, dmu_sii_data};
                        w_cm_be   = dmu_sii_be;
                    end else begin
                        w_cm_data = {dmu_sii_data, r_data};
                        w_cm_be   = 16'hFFFF;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            r_beat_cnt <= 2'd0;
        end else if (r_state == ST_IDLE && dmu_sii_hdr_vld) begin
            r_beat_cnt <= dmu_sii_datareq ? 2'd3 : 2'd0;
        end else if (r_state == ST_DATA && r_beat_cnt != 2'd0) begin
            r_beat_cnt <= r_beat_cnt - 2'd1;
        end
    end

    always_ff @(posedge iol2clk) begin
        if (r_state == ST_IDLE && dmu_sii_hdr_vld) begin
            r_hdr    <= dmu_sii_data;
            r_bypass <= dmu_sii_reqbypass;
            r_len    <= dmu_sii_datareq ? 2'd2 : (dmu_sii_datareq16 ? 2'd1 : 2'd0);
        end
        if (r_state == ST_DATA) begin
            case (r_beat_cnt)
                2'd3:    r_data[127:0]   <= dmu_sii_data;
                2'd2:    r_data[255:128] <= dmu_sii_data;
                2'd1:    r_data[383:256] <= dmu_sii_data;
                default: ;
            endcase
        end
    end

    assign w_head_vld = (r_count != '0);
    assign w_full     = (r_count == (PTR_W+1)'(DEPTH));
    assign w_pop      = w_head_vld & rcv_rdy;
    assign w_pop_wr   = w_pop & (r_mem_len[r_rd_ptr] != 2'd0);
    // At full, a same-cycle pop frees the slot the push is about to reuse.
    assign w_push     = w_commit & (~w_full | w_pop);

    always_ff @(posedge iol2clk) begin
        if (w_push) begin
            r_mem_hdr[r_wr_ptr]    <= w_cm_hdr;
            r_mem_data[r_wr_ptr]   <= w_cm_data;
            r_mem_be[r_wr_ptr]     <= w_cm_be;
            r_mem_len[r_wr_ptr]    <= w_cm_len;
            r_mem_bypass[r_wr_ptr] <= w_cm_bypass;
        end
    end

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_ovf_err   <= 1'b0;
            r_proto_err <= 1'b0;
            r_wrack_vld <= 1'b0;
            r_wrack_tag <= 4'h0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
            if (w_commit && !w_push) r_ovf_err   <= 1'b1;
            if (w_proto_set)         r_proto_err <= 1'b1;
            r_wrack_vld <= w_pop_wr;
            r_wrack_tag <= w_pop_wr ? r_mem_hdr[r_rd_ptr][3:0] : 4'h0;
        end
    end

`ifdef DMU_SII_RCV_PARCHK_EN
    logic [7:0] w_par_calc;
    logic       w_par_chk;
    logic       r_par_err;

    for (genvar g = 0; g < 8; g++) begin : g_par
        assign w_par_calc[g] = ^dmu_sii_data[16*g +: 16];
    end

    assign w_par_chk = (r_state == ST_DATA) || dmu_sii_hdr_vld;

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            r_par_err <= 1'b0;
        end else if (w_par_chk && (w_par_calc != dmu_sii_parity)) begin
            r_par_err <= 1'b1;
        end
    end

    assign rcv_par_err = r_par_err;
`else
    logic w_unused_parity;
    assign w_unused_parity = ^dmu_sii_parity;
    assign rcv_par_err     = 1'b0;
`endif

    // Head outputs are gated so an empty FIFO (including during reset) presents all zeros.
    assign rcv_vld           = w_head_vld;
    assign rcv_hdr           = w_head_vld ? r_mem_hdr[r_rd_ptr]    : '0;
    assign rcv_data          = w_head_vld ? r_mem_data[r_rd_ptr]   : '0;
    assign rcv_be            = w_head_vld ? r_mem_be[r_rd_ptr]     : '0;
    assign rcv_len           = w_head_vld ? r_mem_len[r_rd_ptr]    : '0;
    assign rcv_bypass        = w_head_vld ? r_mem_bypass[r_rd_ptr] : 1'b0;
    assign rcv_full          = w_full;
    assign rcv_ovf_err       = r_ovf_err;
    assign rcv_proto_err     = r_proto_err;
    assign sii_dmu_wrack_vld = r_wrack_vld;
    assign sii_dmu_wrack_tag = r_wrack_tag;

endmodule

// File: tb/tb_dmu_sii_inb_rcv.sv
// Self-checking bench for dmu_sii_inb_rcv: vector table plus hand-written corner sequences,
// with a scoreboard queue compared on every FIFO pop and on every write-ack cycle.
module tb_dmu_sii_inb_rcv;

    logic           clk;
    logic           rst_l;
    logic           hdr_vld;
    logic           reqbypass;
    logic           datareq;
    logic           datareq16;
    logic [127:0]   data;
    logic [7:0]     parity;
    logic [15:0]    be;
    logic           wrack_vld;
    logic [3:0]     wrack_tag;
    logic           rcv_vld;
    logic           rcv_rdy;
    logic [127:0]   rcv_hdr;
    logic [511:0]   rcv_data;
    logic [15:0]    rcv_be;
    logic [1:0]     rcv_len;
    logic           rcv_bypass;
    logic           rcv_full;
    logic           rcv_ovf_err;
    logic           rcv_proto_err;
    logic           rcv_par_err;

`ifdef DMU_SII_RCV_PARCHK_EN
    localparam logic EXP_PAR = 1'b1;
`else
    localparam logic EXP_PAR = 1'b0;
`endif

    dmu_sii_inb_rcv #(.DEPTH(4), .PTR_W(2)) dut (
        .iol2clk           (clk),
        .rst_l             (rst_l),
        .dmu_sii_hdr_vld   (hdr_vld),
        .dmu_sii_reqbypass (reqbypass),
        .dmu_sii_datareq   (datareq),
        .dmu_sii_datareq16 (datareq16),
        .dmu_sii_data      (data),
        .dmu_sii_parity    (parity),
        .dmu_sii_be        (be),
        .sii_dmu_wrack_vld (wrack_vld),
        .sii_dmu_wrack_tag (wrack_tag),
        .rcv_vld           (rcv_vld),
        .rcv_rdy           (rcv_rdy),
        .rcv_hdr           (rcv_hdr),
        .rcv_data          (rcv_data),
        .rcv_be            (rcv_be),
        .rcv_len           (rcv_len),
        .rcv_bypass        (rcv_bypass),
        .rcv_full          (rcv_full),
        .rcv_ovf_err       (rcv_ovf_err),
        .rcv_proto_err     (rcv_proto_err),
        .rcv_par_err       (rcv_par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 header only, 1 16B, 2 64B, 3 both datareq flags (protocol error, handled as 64B)
    typedef struct {
        logic [127:0] hdr;
        logic [1:0]   kind;
        logic         byp;
        logic [15:0]  be;
        logic [127:0] b0;
        logic [127:0] b1;
        logic [127:0] b2;
        logic [127:0] b3;
        int           flip;
        logic [1:0]   exp_len;
        logic [15:0]  exp_be;
    } vec_t;

    typedef struct {
        logic [127:0] hdr;
        logic [511:0] data;
        logic [15:0]  be;
        logic [1:0]   len;
        logic         byp;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    logic pend_vld;
    logic [3:0] pend_tag;
    int n_checks;
    int n_errors;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] par(input logic [127:0] d);
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = ^d[16*i +: 16];
        return p;
    endfunction

    function automatic vec_t mkv(input logic [127:0] hdr, input logic [1:0] kind, input logic byp,
                                 input logic [15:0] bev, input logic [31:0] seed, input int flip);
        vec_t v;
        v.hdr  = hdr;
        v.kind = kind;
        v.byp  = byp;
        v.be   = bev;
        v.b0   = {4{seed}};
        v.b1   = {4{seed + 32'h1111_1111}};
        v.b2   = {4{seed ^ 32'hFFFF_0000}};
        v.b3   = {seed, ~seed, seed, 32'h5A5A_A5A5};
        v.flip = flip;
        v.exp_len = (kind == 2'd0) ? 2'd0 : (kind == 2'd1) ? 2'd1 : 2'd2;
        v.exp_be  = (kind == 2'd0) ? 16'h0 : (kind == 2'd1) ? bev : 16'hFFFF;
        return v;
    endfunction

    // Starts at posedge+1, returns at posedge+1 just after the commit edge with inputs idle.
    task automatic send(input vec_t v, input bit accept);
        exp_t e;
        logic [127:0] beats [4];
        int n;
        beats = '{v.b0, v.b1, v.b2, v.b3};
        n = (v.kind >= 2'd2) ? 4 : int'(v.kind);
        e.hdr  = v.hdr;
        e.len  = v.exp_len;
        e.be   = v.exp_be;
        e.byp  = v.byp;
        e.data = (v.kind >= 2'd2) ? {v.b3, v.b2, v.b1, v.b0} :
                 (v.kind == 2'd1) ? {384'd0, v.b0} : 512'd0;
        if (accept) q.push_back(e);
        hdr_vld   = 1'b1;
        reqbypass = v.byp;
        datareq   = v.kind[1];
        datareq16 = (v.kind == 2'd1) || (v.kind == 2'd3);
        data      = v.hdr;
        parity    = par(v.hdr) ^ ((v.flip == 0) ? 8'h01 : 8'h00);
        @(posedge clk); #1;
        hdr_vld = 1'b0; reqbypass = 1'b0; datareq = 1'b0; datareq16 = 1'b0;
        for (int i = 0; i < n; i++) begin
            data   = beats[i];
            parity = par(beats[i]) ^ ((v.flip == i + 1) ? 8'h01 : 8'h00);
            be     = v.be;
            @(posedge clk); #1;
        end
        data = '0; parity = '0; be = '0;
    endtask

    task automatic drain(input int maxc);
        int c;
        c = 0;
        rcv_rdy = 1'b1;
        while ((q.size() != 0 || rcv_vld) && c < maxc) begin
            @(posedge clk); #1;
            c++;
        end
        chk("drain_queue_empty", q.size(), 0);
        chk("drain_vld_low", rcv_vld, 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_l = 1'b0;
        q.delete();
        pend_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_l = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_vld"}, rcv_vld, 0);
        chk({tag, "_hdr"}, rcv_hdr, 0);
        chk({tag, "_data"}, rcv_data, 0);
        chk({tag, "_be"}, rcv_be, 0);
        chk({tag, "_len"}, rcv_len, 0);
        chk({tag, "_bypass"}, rcv_bypass, 0);
        chk({tag, "_full"}, rcv_full, 0);
        chk({tag, "_ovf"}, rcv_ovf_err, 0);
        chk({tag, "_proto"}, rcv_proto_err, 0);
        chk({tag, "_par"}, rcv_par_err, 0);
        chk({tag, "_wrack_vld"}, wrack_vld, 0);
        chk({tag, "_wrack_tag"}, wrack_tag, 0);
    endtask

    // A pop seen here happens on the next posedge; its write-ack is due one negedge later.
    always @(negedge clk) begin
        chk("wrack_vld", wrack_vld, pend_vld);
        if (pend_vld) chk("wrack_tag", wrack_tag, pend_tag);
        pend_vld = 1'b0;
        if (rcv_vld && rcv_rdy) begin
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_pop: got hdr %0h expected no packet", rcv_hdr);
            end else begin
                mon_e = q.pop_front();
                chk("pop_hdr", rcv_hdr, mon_e.hdr);
                chk("pop_data", rcv_data, mon_e.data);
                chk("pop_be", rcv_be, mon_e.be);
                chk("pop_len", rcv_len, mon_e.len);
                chk("pop_bypass", rcv_bypass, mon_e.byp);
                pend_vld = (mon_e.len != 2'd0);
                pend_tag = mon_e.hdr[3:0];
            end
        end
    end

    initial begin
        n_checks = 0; n_errors = 0;
        pend_vld = 1'b0; pend_tag = 4'h0;
        rst_l = 1'b0; hdr_vld = 1'b0; reqbypass = 1'b0; datareq = 1'b0; datareq16 = 1'b0;
        data = '0; parity = '0; be = '0; rcv_rdy = 1'b0;

        tbl[0] = '{128'h0000_0000_0000_0000_0000_0000_0000_100A, 2'd1, 1'b0, 16'h00FF,
                   128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98, '0, '0, '0, -1, 2'd1, 16'h00FF};
        tbl[1] = '{128'h1111_2222_3333_4444_5555_6666_7777_0003, 2'd2, 1'b0, 16'h1234,
                   128'hB0B0_0000_0000_0000_0000_0000_0000_00B0, 128'hB1B1_0000_0000_0000_0000_0000_0000_00B1,
                   128'hB2B2_0000_0000_0000_0000_0000_0000_00B2, 128'hB3B3_0000_0000_0000_0000_0000_0000_00B3,
                   -1, 2'd2, 16'hFFFF};
        tbl[2] = '{128'hCAFE_0000_0000_0000_0000_0000_0000_000C, 2'd0, 1'b1, 16'hBEEF,
                   '0, '0, '0, '0, -1, 2'd0, 16'h0000};
        tbl[3] = '{128'h0000_0000_0000_0000_ABCD_0000_0000_0007, 2'd1, 1'b1, 16'h8001,
                   128'h0F0F_F0F0_0F0F_F0F0_1234_5678_9ABC_DEF0, '0, '0, '0, -1, 2'd1, 16'h8001};
        tbl[4] = '{128'h8000_0000_0000_0000_0000_0000_0000_000F, 2'd2, 1'b1, 16'h0000,
                   128'h1, 128'h2, 128'h3, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
                   -1, 2'd2, 16'hFFFF};

        // Reset state
        repeat (2) @(posedge clk); #1;
        check_zero("reset");
        rst_l = 1'b1;
        @(posedge clk); #1;

        // Header-only, tag 5: head valid one cycle after the commit edge, no write-ack
        rcv_rdy = 1'b1;
        chk("hdronly_vld_before", rcv_vld, 0);
        send(mkv(128'h0000_0000_0000_0000_0000_0000_0000_0005, 2'd0, 1'b0, 16'h0, 32'h0, -1), 1'b1);
        chk("hdronly_vld_latency", rcv_vld, 1);
        chk("hdronly_len", rcv_len, 0);
        chk("hdronly_tag", rcv_hdr[3:0], 4'h5);
        repeat (3) @(posedge clk); #1;

        // Vector table, back to back with downstream always ready
        for (int i = 0; i < 5; i++) send(tbl[i], 1'b1);
        drain(40);
        chk("tbl_proto_clear", rcv_proto_err, 0);
        chk("tbl_ovf_clear", rcv_ovf_err, 0);

        // Both datareq flags: protocol error, packet taken as 64B
        send(mkv(128'h0000_0000_0000_0000_0000_0000_0000_00D2, 2'd3, 1'b0, 16'h0, 32'h3C3C_0001, -1), 1'b1);
        chk("proto_err_set", rcv_proto_err, 1);
        drain(20);

        // 64B held at the head while not ready, then a single write-ack
        rcv_rdy = 1'b0;
        send(mkv(128'h0000_0000_0000_0000_0000_0000_0000_0046, 2'd2, 1'b0, 16'h0, 32'h7700_0001, -1), 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("hold_vld", rcv_vld, 1);
            chk("hold_data", rcv_data, q[0].data);
            chk("hold_be", rcv_be, 16'hFFFF);
        end
        @(posedge clk); #1;
        drain(20);

        // Overflow: four fill the FIFO, the fifth is dropped
        do_reset();
        chk("rst_clears_proto", rcv_proto_err, 0);
        rcv_rdy = 1'b0;
        for (int k = 0; k < 4; k++)
            send(mkv(128'(k + 1), 2'd0, 1'b0, 16'h0, 32'h0, -1), 1'b1);
        chk("ovf_full_after4", rcv_full, 1);
        chk("ovf_err_before", rcv_ovf_err, 0);
        send(mkv(128'h0000_0000_0000_0000_0000_0000_0000_0099, 2'd0, 1'b0, 16'h0, 32'h0, -1), 1'b0);
        chk("ovf_err_set", rcv_ovf_err, 1);
        chk("ovf_still_full", rcv_full, 1);
        drain(20);

        // Fifth commit coincides with a pop: accepted, no error
        do_reset();
        chk("rst_clears_ovf", rcv_ovf_err, 0);
        rcv_rdy = 1'b0;
        for (int k = 0; k < 4; k++)
            send(mkv(128'(k + 8'h21), 2'd0, 1'b0, 16'h0, 32'h0, -1), 1'b1);
        rcv_rdy = 1'b1;
        send(mkv(128'h0000_0000_0000_0000_0000_0000_0000_0029, 2'd0, 1'b0, 16'h0, 32'h0, -1), 1'b1);
        rcv_rdy = 1'b0;
        chk("popfull_still_full", rcv_full, 1);
        chk("popfull_no_ovf", rcv_ovf_err, 0);
        drain(20);

        // Asynchronous reset during beat 2 of a 64B write, with a stale packet at the head
        send(mkv(128'h0000_0000_0000_0000_0000_0000_0000_0006, 2'd1, 1'b0, 16'h0F0F, 32'h6666_0000, -1), 1'b1);
        rcv_rdy = 1'b0;
        send(mkv(128'h0000_0000_0000_0000_0000_0000_0000_0016, 2'd1, 1'b0, 16'h0F0F, 32'h6666_0001, -1), 1'b1);
        chk("midrst_vld_before", rcv_vld, 1);
        hdr_vld = 1'b1; datareq = 1'b1;
        data = 128'h0000_0000_0000_0000_0000_0000_0000_0008; parity = par(data);
        @(posedge clk); #1;
        hdr_vld = 1'b0; datareq = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data = {4{32'h1000_0000 + 32'(i)}};
            parity = par(data);
            if (i < 2) begin
                @(posedge clk); #1;
            end
        end
        rst_l = 1'b0;
        #1;
        check_zero("midrst");
        q.delete();
        pend_vld = 1'b0;
        data = '0; parity = '0;
        repeat (2) @(posedge clk);
        #1 rst_l = 1'b1;
        rcv_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midrst_no_stale", rcv_vld, 0);
        end
        @(posedge clk); #1;
        send(mkv(128'h0000_0000_0000_0000_0000_0000_0000_000B, 2'd1, 1'b0, 16'hF00F, 32'hB0B0_1234, -1), 1'b1);
        drain(20);

        // Flipped parity bit on a data beat: packet still delivered and acked
        chk("par_err_before", rcv_par_err, 0);
        send(mkv(128'h0000_0000_0000_0000_0000_0000_0000_000E, 2'd2, 1'b0, 16'h0, 32'hE1E1_0000, 2), 1'b1);
        @(posedge clk); #1;
        chk("par_err_after", rcv_par_err, EXP_PAR);
        drain(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
